// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: JTAG DTM DMI access register and DMI request/response handshake FSM
//
// Ports:
//   tck_i, trst_ni            clock and synchronous active-low reset
//   test_logic_reset_i        TAP in Test-Logic-Reset, same effect as reset
//   dmi_access_i              IR selects DMIACCESS; DR strobes are ignored otherwise
//   capture_dr_i/shift_dr_i/update_dr_i, dmi_tdi_i, dmi_tdo_o   DR scan path
//   dmi_reset_i               dtmcs.dmireset, clears the sticky error
//   dmi_error_o               sticky status for dtmcs.dmistat
//   dmi_req_*                 request channel to the DM (op 1 = read, 2 = write)
//   dmi_resp_*                response channel from the DM (resp 0 = ok)
//
// Build option: define DMI_RESP_TIMEOUT_EN to abandon a WAIT state after
// TimeoutCycles cycles without a response; otherwise the block waits forever.
module dmi_access_ctrl #(
   parameter int unsigned AddrWidth     = 7,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 test_logic_reset_i,
   input  logic                 dmi_access_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 dmi_reset_i,
   input  logic                 dmi_tdi_i,
   output logic                 dmi_tdo_o,
   output logic [1:0]           dmi_error_o,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [31:0]          dmi_req_data_o,
   output logic [1:0]           dmi_req_op_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_resp_i
);
   localparam int unsigned DrWidth = AddrWidth + 34;
   typedef enum logic [2:0] {IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE} state_e;
   state_e state_q, state_d;
   logic [DrWidth-1:0] shift_q, shift_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0] error_q, error_d;
   logic clear, capture, shift, update, busy, set_busy, set_fail, timeout;
   logic [AddrWidth-1:0] dr_addr;
   logic [31:0] dr_data;
   logic [1:0] dr_op;
   assign clear    = !trst_ni || test_logic_reset_i;
   assign capture  = dmi_access_i && capture_dr_i;
   assign shift    = dmi_access_i && shift_dr_i;
   assign update   = dmi_access_i && update_dr_i;
   assign busy     = state_q != IDLE;
   assign dr_addr  = shift_q[DrWidth-1 -: AddrWidth];
   assign dr_data  = shift_q[33:2];
   assign dr_op    = shift_q[1:0];
   // Any DR capture or update while a transaction is outstanding is a busy violation.
   assign set_busy = busy && (capture || update);
`ifdef DMI_RESP_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   logic [CntWidth-1:0] cnt_q, cnt_d;
   // Counts consecutive WAIT cycles without a response; it is zero in every
   // non-WAIT state, so each WAIT entry starts from zero.
   assign timeout = dmi_resp_ready_o && !dmi_resp_valid_i && cnt_q == CntWidth'(TimeoutCycles - 1);
   always_comb cnt_d = (dmi_resp_ready_o && !dmi_resp_valid_i && !timeout) ? cnt_q + 1'b1 : '0;
   always_ff @(posedge tck_i) begin
      if (clear) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      set_fail = 1'b0;
      if (capture) shift_d = {addr_q, rdata_q, busy ? 2'd3 : error_q};
      else if (shift) shift_d = {dmi_tdi_i, shift_q[DrWidth-1:1]};
      case (state_q)
         IDLE: begin
            if (update && error_q == 2'd0 && (dr_op == 2'd1 || dr_op == 2'd2)) begin
               addr_d  = dr_addr;
               wdata_d = dr_data;
               state_d = dr_op == 2'd1 ? READ : WRITE;
            end
         end
         READ:  state_d = dmi_req_ready_i ? WAIT_READ : READ;
         WRITE: state_d = dmi_req_ready_i ? WAIT_WRITE : WRITE;
         WAIT_READ, WAIT_WRITE: begin
            if (dmi_resp_valid_i) begin
               state_d  = IDLE;
               rdata_d  = state_q == WAIT_READ ? dmi_resp_data_i : rdata_q;
               set_fail = dmi_resp_resp_i != 2'd0;
            end else if (timeout) begin
               state_d  = IDLE;
               set_fail = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear beats any set; otherwise a nonzero error is sticky.
      error_d = dmi_reset_i ? 2'd0 :
                error_q != 2'd0 ? error_q :
                set_busy ? 2'd3 :
                set_fail ? 2'd2 : 2'd0;
   end
   always_ff @(posedge tck_i) begin
      if (clear) begin
         state_q <= IDLE;
         shift_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end
   assign dmi_tdo_o        = shift_q[0];
   assign dmi_error_o      = error_q;
   assign dmi_req_valid_o  = state_q == READ || state_q == WRITE;
   assign dmi_resp_ready_o = state_q == WAIT_READ || state_q == WAIT_WRITE;
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_data_o   = wdata_q;
   assign dmi_req_op_o     = state_q == READ ? 2'd1 : state_q == WRITE ? 2'd2 : 2'd0;
endmodule

// File: tb/tb_dmi_access_ctrl.sv
// tb_dmi_access_ctrl: randomized scan/DM traffic checked against a transaction-level model
module tb_dmi_access_ctrl;
   localparam int AW = 7;
   localparam int W  = AW + 34;
   logic tck = 1'b0;
   always #5 tck = ~tck;
   logic trst_n, tlr, access, capture, shift, update, dmi_reset, tdi, tdo;
   logic [1:0] error;
   logic req_valid, req_ready, resp_valid, resp_ready;
   logic [AW-1:0] req_addr;
   logic [31:0] req_data, resp_data;
   logic [1:0] req_op, resp_resp;
   dmi_access_ctrl #(.AddrWidth(AW), .TimeoutCycles(255)) dut (
      .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr), .dmi_access_i(access),
      .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update),
      .dmi_reset_i(dmi_reset), .dmi_tdi_i(tdi), .dmi_tdo_o(tdo), .dmi_error_o(error),
      .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready), .dmi_req_addr_o(req_addr),
      .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
      .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
      .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp)
   );
   int checks = 0;
   int errors = 0;
   // Model: phase 0 = no transaction, 1 = request offered, 2 = awaiting response.
   int m_phase;
   logic [1:0] m_kind, m_err;
   logic [AW-1:0] m_addr;
   logic [31:0] m_wdata, m_rdata;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge tck);
      #1;
   endtask
   task automatic model_reset();
      m_phase = 0;
      m_kind  = 2'd0;
      m_err   = 2'd0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
   endtask
   task automatic scan(input logic acc, input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [31:0] data, input logic clr);
      logic [W-1:0] din, got;
      logic [1:0] exp_op;
      din    = {addr, data, op};
      exp_op = m_phase != 0 ? 2'd3 : m_err;
      access = acc;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      if (acc && m_phase != 0 && m_err == 2'd0) m_err = 2'd3;
      shift = 1'b1;
      for (int i = 0; i < W; i++) begin
         got[i] = tdo;
         tdi = din[i];
         tick();
      end
      shift = 1'b0;
      update = 1'b1;
      dmi_reset = clr;
      tick();
      update = 1'b0;
      dmi_reset = 1'b0;
      access = 1'b1;
      if (acc) begin
         check("capture_word", 64'(got), 64'({m_addr, m_rdata, exp_op}));
         if (m_phase != 0) begin
            if (m_err == 2'd0) m_err = 2'd3;
         end else if (m_err == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            m_phase = 1;
            m_kind  = op;
            m_addr  = addr;
            m_wdata = data;
         end
      end
      if (clr) m_err = 2'd0;
      check("valid_after_update", 64'(req_valid), 64'(m_phase == 1));
      check("error_after_update", 64'(error), 64'(m_err));
   endtask
   task automatic check_payload();
      check("req_valid_held", 64'(req_valid), 64'd1);
      check("req_addr", 64'(req_addr), 64'(m_addr));
      check("req_data", 64'(req_data), 64'(m_wdata));
      check("req_op", 64'(req_op), 64'(m_kind));
   endtask
   task automatic dm_request(input int dly);
      for (int k = 0; k < dly; k++) begin
         check_payload();
         tick();
      end
      req_ready = 1'b1;
      check_payload();
      tick();
      req_ready = 1'b0;
      m_phase = 2;
      check("valid_after_accept", 64'(req_valid), 64'd0);
      check("resp_ready_in_wait", 64'(resp_ready), 64'd1);
   endtask
   task automatic dm_respond(input logic [31:0] data, input logic [1:0] code, input logic clr);
      resp_valid = 1'b1;
      resp_data  = data;
      resp_resp  = code;
      dmi_reset  = clr;
      tick();
      resp_valid = 1'b0;
      dmi_reset  = 1'b0;
      if (m_kind == 2'd1) m_rdata = data;
      if (code != 2'd0 && m_err == 2'd0) m_err = 2'd2;
      if (clr) m_err = 2'd0;
      m_phase = 0;
      check("resp_ready_after_resp", 64'(resp_ready), 64'd0);
      check("error_after_resp", 64'(error), 64'(m_err));
   endtask
   task automatic clear_err();
      dmi_reset = 1'b1;
      tick();
      dmi_reset = 1'b0;
      m_err = 2'd0;
      check("error_after_dmireset", 64'(error), 64'd0);
   endtask
   task automatic txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] data,
                      input int dly, input logic busy_scan, input logic [31:0] rdata,
                      input logic [1:0] code, input logic clr);
      scan(1'b1, op, addr, data, 1'b0);
      if (m_phase == 1) begin
         dm_request(dly);
         if (busy_scan) scan(1'b1, 2'($urandom_range(3)), AW'($urandom), $urandom, 1'b0);
         dm_respond(rdata, code, clr);
      end
   endtask
   task automatic reset_mid(input logic use_tlr);
      scan(1'b1, 2'd2, 7'h5a, 32'h1234_5678, 1'b0);
      tick();
      scan(1'b1, 2'd0, 7'h00, 32'h0, 1'b0);
      check("busy_error_before_reset", 64'(error), 64'd3);
      if (use_tlr) tlr = 1'b1;
      else trst_n = 1'b0;
      tick();
      tlr = 1'b0;
      trst_n = 1'b1;
      model_reset();
      check("reset_valid", 64'(req_valid), 64'd0);
      check("reset_resp_ready", 64'(resp_ready), 64'd0);
      check("reset_error", 64'(error), 64'd0);
      check("reset_tdo", 64'(tdo), 64'd0);
      resp_valid = 1'b1;
      resp_data  = 32'hffff_ffff;
      resp_resp  = 2'd2;
      req_ready  = 1'b1;
      tick();
      resp_valid = 1'b0;
      resp_resp  = 2'd0;
      req_ready  = 1'b0;
      check("late_resp_valid", 64'(req_valid), 64'd0);
      check("late_resp_ready", 64'(resp_ready), 64'd0);
      check("late_resp_error", 64'(error), 64'd0);
      scan(1'b1, 2'd0, 7'h00, 32'h0, 1'b0);
   endtask
   initial begin
      trst_n = 1'b0; tlr = 1'b0; access = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0;
      dmi_reset = 1'b0; tdi = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
      resp_data = '0; resp_resp = '0;
      model_reset();
      tick();
      tick();
      check("por_valid", 64'(req_valid), 64'd0);
      check("por_resp_ready", 64'(resp_ready), 64'd0);
      check("por_error", 64'(error), 64'd0);
      check("por_tdo", 64'(tdo), 64'd0);
      trst_n = 1'b1;
      tick();
      txn(2'd1, 7'h11, 32'h0, 0, 1'b0, 32'hdead_beef, 2'd0, 1'b0);
      scan(1'b1, 2'd0, 7'h00, 32'h0, 1'b0);
      txn(2'd2, 7'h04, 32'h1, 3, 1'b0, 32'h0, 2'd0, 1'b0);
      check("write_error_zero", 64'(error), 64'd0);
      scan(1'b1, 2'd1, 7'h22, 32'h0, 1'b0);
      dm_request(1);
      scan(1'b1, 2'd2, 7'h33, 32'h55, 1'b0);
      dm_respond(32'hcafe_f00d, 2'd0, 1'b0);
      scan(1'b1, 2'd1, 7'h44, 32'h0, 1'b0);
      clear_err();
      txn(2'd1, 7'h55, 32'h0, 2, 1'b0, 32'h0bad_0bad, 2'd2, 1'b0);
      check("fail_error", 64'(error), 64'd2);
      scan(1'b1, 2'd1, 7'h66, 32'h0, 1'b1);
      scan(1'b0, 2'd1, 7'h77, 32'h9, 1'b0);
      tick();
      check("ignored_no_valid", 64'(req_valid), 64'd0);
      reset_mid(1'b0);
      reset_mid(1'b1);
      scan(1'b1, 2'd1, 7'h3c, 32'h0, 1'b0);
      dm_request(0);
`ifdef DMI_RESP_TIMEOUT_EN
      begin
         int n = 0;
         while (resp_ready && n < 400) begin
            tick();
            n++;
         end
         check("timeout_cycles", 64'(n), 64'd255);
         m_phase = 0;
         if (m_err == 2'd0) m_err = 2'd2;
         check("timeout_error", 64'(error), 64'(m_err));
         clear_err();
      end
`else
      repeat (1000) tick();
      check("no_timeout_resp_ready", 64'(resp_ready), 64'd1);
      check("no_timeout_error", 64'(error), 64'd0);
      dm_respond(32'h1357_9bdf, 2'd0, 1'b0);
`endif
      for (int t = 0; t < 40; t++) begin
         txn(2'($urandom_range(3)), AW'($urandom), $urandom, int'($urandom_range(3)),
             $urandom_range(4) == 0, $urandom,
             $urandom_range(3) == 0 ? 2'($urandom_range(3, 1)) : 2'd0,
             $urandom_range(5) == 0);
         if (m_err != 2'd0 && $urandom_range(1) == 1) clear_err();
         repeat ($urandom_range(2)) tick();
      end
      scan(1'b1, 2'd0, 7'h00, 32'h0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmi_access_ctrl.md
DMI_ACCESS_CTRL -- requirements
Module: dmi_access_ctrl

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 7, giving the DMI address width.
REQ-002 The block SHALL have parameter TimeoutCycles, default 255, giving the response timeout in tck_i cycles (used only when DMI_RESP_TIMEOUT_EN is defined).
REQ-003 The block SHALL have port tck_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port trst_ni, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have the following TAP-side inputs, 1 bit each:
- test_logic_reset_i: TAP in Test-Logic-Reset.
- dmi_access_i: IR selects DMIACCESS.
- capture_dr_i, shift_dr_i, update_dr_i: TAP DR strobes.
- dmi_reset_i: dtmcs.dmireset.
- dmi_tdi_i: serial data in.
REQ-006 The block SHALL have the following TAP-side outputs:
- dmi_tdo_o, 1 bit: serial data out.
- dmi_error_o, 2 bits: sticky status to dtmcs.dmistat.
REQ-007 The block SHALL have the following request channel to the DM:
- dmi_req_valid_o (output, 1 bit).
- dmi_req_ready_i (input, 1 bit).
- dmi_req_addr_o (output, AddrWidth bits).
- dmi_req_data_o (output, 32 bits).
- dmi_req_op_o (output, 2 bits: 1 = read, 2 = write).
REQ-008 The block SHALL have the following response channel from the DM:
- dmi_resp_valid_i (input, 1 bit).
- dmi_resp_ready_o (output, 1 bit).
- dmi_resp_data_i (input, 32 bits).
- dmi_resp_resp_i (input, 2 bits: 0 = ok, otherwise failed).

Function
REQ-009 The block SHALL hold a DR shift register of AddrWidth+34 bits laid out {addr, data[31:0], op[1:0]}, with op as the LSBs.
REQ-010 dmi_tdo_o SHALL equal shift register bit 0, combinationally.
REQ-011 On capture_dr_i with dmi_access_i = 1, the shift register SHALL load {last request addr, last read data, op}, where op = dmi_error_o, or 3 if the FSM is not IDLE.
REQ-012 If REQ-011 captures while the FSM is not IDLE, error SHALL also be set to 3.
REQ-013 On shift_dr_i with dmi_access_i = 1, the shift register SHALL shift right, with dmi_tdi_i entering the MSB.
REQ-014 The FSM SHALL have states IDLE, READ, WAIT_READ, WRITE and WAIT_WRITE.
REQ-015 On update_dr_i with dmi_access_i = 1, in IDLE, with error = 0:
- op = 1 SHALL latch addr/data and go to READ.
- op = 2 SHALL latch addr/data and go to WRITE.
- op = 0 or 3 SHALL leave the FSM in IDLE.
REQ-016 On update_dr_i with dmi_access_i = 1, if the FSM is not IDLE, the request SHALL be dropped and error set to 3.
REQ-017 On update_dr_i with dmi_access_i = 1, in IDLE with error ≠ 0, the request SHALL be dropped and error left unchanged.
REQ-018 dmi_req_valid_o SHALL be 1 exactly in READ/WRITE.
REQ-019 Addr, data and op SHALL be stable while dmi_req_valid_o = 1.
REQ-020 When dmi_req_valid_o & dmi_req_ready_i, READ SHALL go to WAIT_READ and WRITE SHALL go to WAIT_WRITE on the next edge.
REQ-021 dmi_req_valid_o SHALL be 1 no earlier than the cycle after update_dr_i.
REQ-022 dmi_resp_ready_o SHALL be 1 exactly in WAIT_READ/WAIT_WRITE.
REQ-023 On dmi_resp_valid_i in a WAIT state, the FSM SHALL return to IDLE.
REQ-024 On a response in WAIT_READ, dmi_resp_data_i SHALL be stored as the last read data.
REQ-025 On a response in WAIT_WRITE, dmi_resp_data_i SHALL be discarded.
REQ-026 If dmi_resp_resp_i ≠ 0 on a response and error = 0, error SHALL be set to 2.
REQ-027 Error SHALL be sticky: nonzero values are never overwritten except by clear.
REQ-028 dmi_reset_i SHALL clear error to 0 and SHALL NOT change FSM state.
REQ-029 If dmi_reset_i coincides with a set-error event, the clear SHALL win.
REQ-030 Strobes with dmi_access_i = 0 SHALL be ignored.

Reset
REQ-031 trst_ni = 0 at a tck_i edge SHALL set:
- FSM to IDLE.
- dmi_req_valid_o = 0 and dmi_resp_ready_o = 0.
- Error = 0.
- Shift register, stored addr and read data to 0.
REQ-032 test_logic_reset_i = 1 SHALL have the same effect as REQ-031, including when asserted mid-transaction; a late DM response SHALL be ignored.

Configuration
REQ-033 With DMI_RESP_TIMEOUT_EN defined, a counter SHALL run in the WAIT states.
REQ-034 After TimeoutCycles cycles without dmi_resp_valid_i, the FSM SHALL go to IDLE with error set to 2 (if error is 0).
REQ-035 The timeout counter SHALL restart on entry to each WAIT state.
REQ-036 Without DMI_RESP_TIMEOUT_EN, the block SHALL contain no counter and SHALL wait indefinitely.

Verification
REQ-037 Read: shift op=1, addr=0x11; DM returns 0xDEADBEEF with resp 0; next capture/shift -> TDO yields op=0, data 0xDEADBEEF, addr 0x11.
REQ-038 Write: shift op=2, addr=0x04, data=0x1; DM ready held 0 for 3 cycles -> valid held with stable payload; one request; error 0.
REQ-039 Busy: update_dr a second request while in WAIT_READ -> dropped; dmi_error_o=3; subsequent requests ignored until dmi_reset_i, after which error=0.
REQ-040 Failure: DM responds with resp 2 -> dmi_error_o=2; an update_dr in the same cycle as dmi_reset_i -> error 0.
REQ-041 Reset: trst_ni low, or test_logic_reset_i high, during WRITE -> valid=0 next edge, IDLE, error 0; late response ignored.
REQ-042 With DMI_RESP_TIMEOUT_EN, no response for 255 cycles -> IDLE, error=2; without the macro, the block still waits at cycle 1000.
